// File: rtl/uart_rx_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Bundles the byte stream coming from the UART receiver and the validated-frame
// handshake going to the command logic.
//   master : the frame sequencer. It drives rx_en, frame_data, frame_valid,
//            err_*, drop_cnt and busy. It receives rx_data, rx_valid,
//            rx_frame_err and frame_ack.
//   slave  : the surrounding logic (receiver plus consumer), which has the
//            opposite directions.
// ---------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if #(
    parameter int PAYLOAD_LEN = 4
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_frame_err;
    logic                     rx_en;
    logic [8*PAYLOAD_LEN-1:0] frame_data;
    logic                     frame_valid;
    logic                     frame_ack;
    logic                     err_chksum;
    logic                     err_timeout;
    logic                     err_overrun;
    logic                     err_line;
    logic [7:0]               drop_cnt;
    logic                     busy;

    modport master (
        input  rx_data, rx_valid, rx_frame_err, frame_ack,
        output rx_en, frame_data, frame_valid,
               err_chksum, err_timeout, err_overrun, err_line,
               drop_cnt, busy
    );

    modport slave (
        output rx_data, rx_valid, rx_frame_err, frame_ack,
        input  rx_en, frame_data, frame_valid,
               err_chksum, err_timeout, err_overrun, err_line,
               drop_cnt, busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Frame sequencer behind a UART receiver. It hunts for HEADER, collects
// PAYLOAD_LEN payload bytes plus a mod-256 sum checksum, and aborts a frame
// whose inter-byte gap exceeds TIMEOUT_BITS bit times. Good frames are held on
// frame_valid until frame_ack.
// Ports:
//   clk    : system clock. Everything runs on its rising edge.
//   reset  : synchronous, active-high reset.
//   bus    : uart_rx_frame_ctrl_if.master. It carries the receiver bytes, the
//            frame handshake, the error pulses, drop_cnt and busy. All of its
//            outputs are registered.
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter int         CLK_FREQ     = 100_000_000,
    parameter int         BAUD         = 9600,
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         PAYLOAD_LEN  = 4,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_rx_frame_ctrl_if.master bus
);
    localparam int BIT_CLKS = CLK_FREQ / BAUD;
    localparam int TO_LIMIT = TIMEOUT_BITS * BIT_CLKS;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam int IDX_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Running checksum: the payload bytes are summed modulo 256.
    function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t                   state_r, state_s;
    logic [IDX_W-1:0]         idx_r, idx_s;
    logic [7:0]               sum_r, sum_s;
    logic [8*PAYLOAD_LEN-1:0] buf_r, buf_s;
    logic [TO_W-1:0]          to_cnt_r, to_cnt_s;
    logic [8*PAYLOAD_LEN-1:0] frame_data_r, frame_data_s;
    logic [7:0]               drop_cnt_r, drop_cnt_s;
    logic                     frame_valid_r, busy_r, rx_en_r;
    logic                     err_chksum_r, err_timeout_r, err_overrun_r, err_line_r;
    logic                     err_chksum_s, err_timeout_s, err_overrun_s, err_line_s;
    logic                     hdr_ok_s, to_hit_s;

    assign hdr_ok_s = (bus.rx_data == HEADER) && !bus.rx_frame_err;
    assign to_hit_s = (to_cnt_r == TO_LAST);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        sum_s         = sum_r;
        buf_s         = buf_r;
        to_cnt_s      = to_cnt_r;
        frame_data_s  = frame_data_r;
        drop_cnt_s    = drop_cnt_r;
        err_chksum_s  = 1'b0;
        err_timeout_s = 1'b0;
        err_overrun_s = 1'b0;
        err_line_s    = 1'b0;
        case (state_r)
            // In HOLD, an acknowledged cycle behaves exactly like IDLE, so that a
            // header arriving together with the ack starts the next frame at once.
            ST_IDLE, ST_HOLD: begin
                if ((state_r == ST_HOLD) && !bus.frame_ack) begin
                    if (bus.rx_valid) begin
                        err_overrun_s = 1'b1;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end else if (bus.rx_valid) begin
                    if (hdr_ok_s) begin
                        state_s  = ST_PAYLOAD;
                        idx_s    = '0;
                        sum_s    = 8'h00;
                        to_cnt_s = '0;
                    end else begin
                        state_s = ST_IDLE;
                        if (drop_cnt_r != 8'hFF) begin
                            drop_cnt_s = drop_cnt_r + 8'd1;
                        end else begin
                            drop_cnt_s = drop_cnt_r;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (bus.rx_valid) begin
                    to_cnt_s = '0;
                    if (bus.rx_frame_err) begin
                        err_line_s = 1'b1;
                        state_s    = ST_IDLE;
                    end else begin
                        buf_s[{idx_r, 3'b000} +: 8] = bus.rx_data;
                        sum_s = sum_add(sum_r, bus.rx_data);
                        if (idx_r == IDX_LAST) begin
                            idx_s   = '0;
                            state_s = ST_CHECK;
                        end else begin
                            idx_s = idx_r + IDX_W'(1);
                        end
                    end
                end else if (to_hit_s) begin
                    err_timeout_s = 1'b1;
                    to_cnt_s      = '0;
                    state_s       = ST_IDLE;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            // The payload is collected in a shadow buffer. frame_data is only
            // updated here, so it always shows the last good frame.
            ST_CHECK: begin
                if (bus.rx_valid) begin
                    to_cnt_s = '0;
                    if (bus.rx_frame_err) begin
                        err_line_s = 1'b1;
                        state_s    = ST_IDLE;
                    end else if (bus.rx_data == sum_r) begin
                        frame_data_s = buf_r;
                        state_s      = ST_HOLD;
                    end else begin
                        err_chksum_s = 1'b1;
                        state_s      = ST_IDLE;
                    end
                end else if (to_hit_s) begin
                    err_timeout_s = 1'b1;
                    to_cnt_s      = '0;
                    state_s       = ST_IDLE;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            default: begin
                state_s  = ST_IDLE;
                idx_s    = '0;
                to_cnt_s = '0;
            end
        endcase
    end

    // State register and registered outputs. frame_valid and busy are taken
    // from the next state, so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            idx_r         <= '0;
            sum_r         <= 8'h00;
            buf_r         <= '0;
            to_cnt_r      <= '0;
            frame_data_r  <= '0;
            drop_cnt_r    <= 8'h00;
            frame_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            rx_en_r       <= 1'b0;
            err_chksum_r  <= 1'b0;
            err_timeout_r <= 1'b0;
            err_overrun_r <= 1'b0;
            err_line_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            sum_r         <= sum_s;
            buf_r         <= buf_s;
            to_cnt_r      <= to_cnt_s;
            frame_data_r  <= frame_data_s;
            drop_cnt_r    <= drop_cnt_s;
            frame_valid_r <= (state_s == ST_HOLD);
            busy_r        <= (state_s != ST_IDLE);
            rx_en_r       <= 1'b1;
            err_chksum_r  <= err_chksum_s;
            err_timeout_r <= err_timeout_s;
            err_overrun_r <= err_overrun_s;
            err_line_r    <= err_line_s;
        end
    end

    assign bus.rx_en       = rx_en_r;
    assign bus.frame_data  = frame_data_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.err_chksum  = err_chksum_r;
    assign bus.err_timeout = err_timeout_r;
    assign bus.err_overrun = err_overrun_r;
    assign bus.err_line    = err_line_r;
    assign bus.drop_cnt    = drop_cnt_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl.
// The stimulus side runs a frame-level reference model. For each clock it
// pushes the expected events into a queue, each tagged with the cycle in which
// it must appear. An independent monitor pops that queue and compares it with
// what the DUT presents on its outputs.
module tb_uart_rx_frame_ctrl;
    localparam int         P     = 4;
    localparam int         LIMIT = 20 * (1_000_000 / 100_000);
    localparam logic [7:0] HDR   = 8'hA5;
    localparam int EV_FRAME = 0, EV_CHK = 1, EV_TO = 2, EV_OVR = 3, EV_LINE = 4;

    typedef struct {
        int               kind;
        logic [8*P-1:0]   data;
        longint           at;
    } ev_t;

    logic   clk   = 1'b0;
    logic   reset = 1'b1;
    longint cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame_ctrl_if #(.PAYLOAD_LEN(P)) bus ();

    uart_rx_frame_ctrl #(
        .CLK_FREQ(1_000_000), .BAUD(100_000), .HEADER(HDR),
        .PAYLOAD_LEN(P), .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int             checks   = 0;
    int             failures = 0;
    ev_t            expq[$];
    // Reference model state: frame progress, held frame, drop count.
    bit             in_frame = 1'b0;
    bit             holding  = 1'b0;
    logic [7:0]     pay_q[$];
    int             m_gap    = 0;
    int             m_drop   = 0;
    logic [8*P-1:0] m_last   = '0;
    longint         m_fall_at = -1;
    bit             ack_next = 1'b0;
    logic [8*P-1:0] cur_fd   = '0;
    bit             prev_fv  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [8*P-1:0] data, input longint at);
        ev_t e;
        e.kind = kind; e.data = data; e.at = at;
        expq.push_back(e);
    endtask

    task automatic idle_byte(input logic [7:0] d, input bit fe);
        if (d == HDR && !fe) begin
            in_frame = 1'b1; m_gap = 0; pay_q.delete();
        end else if (m_drop < 255) begin
            m_drop++;
        end
    endtask

    // Frame-level reference model, advanced once per clock edge `at`.
    task automatic model_step(input bit v, input logic [7:0] d, input bit fe, input bit ack,
                              input longint at);
        logic [7:0]     s;
        logic [8*P-1:0] packed_pl;
        if (holding) begin
            if (ack) begin
                holding = 1'b0; m_fall_at = at;
                if (v) idle_byte(d, fe);
            end else if (v) begin
                push(EV_OVR, '0, at);
            end
        end else if (in_frame) begin
            if (v) begin
                m_gap = 0;
                if (fe) begin
                    push(EV_LINE, '0, at); in_frame = 1'b0;
                end else if (pay_q.size() < P) begin
                    pay_q.push_back(d);
                end else begin
                    s = 8'h00; packed_pl = '0;
                    for (int i = 0; i < P; i++) begin
                        s = s + pay_q[i];
                        packed_pl[8*i +: 8] = pay_q[i];
                    end
                    if (d == s) begin
                        push(EV_FRAME, packed_pl, at); m_last = packed_pl; holding = 1'b1;
                    end else begin
                        push(EV_CHK, '0, at);
                    end
                    in_frame = 1'b0;
                end
            end else begin
                m_gap++;
                if (m_gap == LIMIT) begin
                    push(EV_TO, '0, at); in_frame = 1'b0;
                end
            end
        end else if (v) begin
            idle_byte(d, fe);
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit fe, input bit ack);
        @(posedge clk); #1;
        bus.rx_valid = v; bus.rx_data = d; bus.rx_frame_err = fe; bus.frame_ack = ack;
        model_step(v, d, fe, ack, cyc + 1);
    endtask

    task automatic send(input logic [7:0] d, input bit fe, input int gap);
        for (int i = 0; i < gap; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, d, fe, ack_next);
        ack_next = 1'b0;
    endtask

    task automatic send_frame(input logic [8*P-1:0] pl, input logic [7:0] chk, input int gap);
        send(HDR, 1'b0, gap);
        for (int i = 0; i < P; i++) send(pl[8*i +: 8], 1'b0, gap);
        send(chk, 1'b0, gap);
    endtask

    function automatic logic [7:0] pl_sum(input logic [8*P-1:0] pl);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < P; i++) s = s + pl[8*i +: 8];
        return s;
    endfunction

    function automatic int rgap();
        int r = $urandom_range(0, 39);
        if (r == 38) return LIMIT - 1;
        if (r == 39) return LIMIT;
        if (r < 30) return 0;
        return $urandom_range(1, 3);
    endfunction

    task automatic settle_check(input string tag);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check({tag, "_busy"}, bus.busy, in_frame || holding);
        check({tag, "_frame_valid"}, bus.frame_valid, holding);
        check({tag, "_drop_cnt"}, bus.drop_cnt, m_drop);
        check({tag, "_frame_data"}, bus.frame_data, m_last);
        check({tag, "_pending_events"}, expq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_en"}, bus.rx_en, 1'b0);
        check({tag, "_frame_valid"}, bus.frame_valid, 1'b0);
        check({tag, "_frame_data"}, bus.frame_data, '0);
        check({tag, "_errs"}, {bus.err_chksum, bus.err_timeout, bus.err_overrun, bus.err_line}, 4'h0);
        check({tag, "_drop_cnt"}, bus.drop_cnt, 8'h00);
        check({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        check({tag, "_no_pending"}, expq.size(), 0);
        @(posedge clk); #1;
        reset = 1'b1; bus.rx_valid = 1'b0; bus.frame_ack = 1'b0; ack_next = 1'b0;
        @(posedge clk); @(negedge clk);
        check_reset_outputs(tag);
        @(posedge clk); #1;
        reset = 1'b0;
        in_frame = 1'b0; holding = 1'b0; m_drop = 0; m_last = '0; m_gap = 0;
        pay_q.delete(); expq.delete();
        @(posedge clk); @(negedge clk);
        check({tag, "_rx_en_after"}, bus.rx_en, 1'b1);
    endtask

    // Pops the next expected event and checks its kind, its cycle and its frame payload.
    task automatic expect_ev(input int kind, input logic [8*P-1:0] act, output logic [8*P-1:0] exp_d);
        ev_t e;
        exp_d = act;
        if (expq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event actual=kind%0d required=none cycle=%0d", kind, cyc);
        end else begin
            e = expq.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.at);
            if (kind == EV_FRAME) check("frame_data", act, e.data);
            exp_d = e.data;
        end
    endtask

    // Monitor process
    initial begin
        int             nerr;
        logic [8*P-1:0] dummy;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_fv = 1'b0;
            end else begin
                nerr = int'(bus.err_chksum) + int'(bus.err_timeout) + int'(bus.err_overrun) + int'(bus.err_line);
                check("err_exclusive", nerr <= 1, 1'b1);
                if (bus.err_chksum)  expect_ev(EV_CHK, '0, dummy);
                if (bus.err_timeout) expect_ev(EV_TO, '0, dummy);
                if (bus.err_overrun) expect_ev(EV_OVR, '0, dummy);
                if (bus.err_line)    expect_ev(EV_LINE, '0, dummy);
                if (bus.frame_valid && !prev_fv) expect_ev(EV_FRAME, bus.frame_data, cur_fd);
                else if (bus.frame_valid) check("frame_hold_stable", bus.frame_data, cur_fd);
                else if (prev_fv) check("frame_valid_fall_cycle", cyc, m_fall_at);
                prev_fv = bus.frame_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench did not terminate");
    end

    // Stimulus process
    initial begin
        logic [7:0] b, s, chk;
        bit         fe;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_frame_err = 1'b0; bus.frame_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check("por_rx_en_after", bus.rx_en, 1'b1);

        // Good frame, held until ack.
        send_frame(32'h04030201, 8'h0A, 0);
        repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_frame_data", bus.frame_data, 32'h04030201);
        check("t1_frame_valid_held", bus.frame_valid, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        settle_check("t1");

        // Bad checksum.
        send_frame(32'h04030201, 8'h0B, 1);
        settle_check("t2");

        // Timeout, then a good frame; also the exact gap boundary.
        send(HDR, 1'b0, 0); send(8'h10, 1'b0, 0); send(8'h20, 1'b0, 0);
        repeat (250) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        settle_check("t3_to");
        send_frame(32'hDEADBEEF, pl_sum(32'hDEADBEEF), 2);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        send(HDR, 1'b0, 0); send(8'h01, 1'b0, LIMIT - 1);
        send(8'h02, 1'b0, LIMIT);
        settle_check("t3_edge");

        // Junk before a frame.
        do_reset("t4");
        send(8'h33, 1'b0, 0); send(8'h44, 1'b0, 0);
        send_frame(32'h44332211, 8'hAA, 0);
        settle_check("t4");
        check("t4_drop_cnt", bus.drop_cnt, 8'd2);
        check("t4_frame_data", bus.frame_data, 32'h44332211);

        // Overrun while held, then ack together with the next header.
        send(8'h55, 1'b0, 0);
        settle_check("t5_ovr");
        check("t5_data_kept", bus.frame_data, 32'h44332211);
        ack_next = 1'b1;
        send_frame(32'hA5A5A5A5, pl_sum(32'hA5A5A5A5), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Line errors: in a payload byte, and on a header in IDLE.
        send(HDR, 1'b0, 0); send(8'h01, 1'b1, 0);
        send(HDR, 1'b1, 0);
        settle_check("t5_line");

        // Reset in mid-frame.
        send(HDR, 1'b0, 0); send(8'h01, 1'b0, 0); send(8'h02, 1'b0, 0);
        do_reset("t6");
        send_frame(32'h0C0B0A09, pl_sum(32'h0C0B0A09), 0);
        settle_check("t6");
        check("t6_frame_data", bus.frame_data, 32'h0C0B0A09);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // drop_cnt saturation.
        do_reset("sat");
        for (int i = 0; i < 300; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == HDR) b = 8'h00;
            send(b, 1'b0, 0);
        end
        settle_check("sat");
        check("sat_drop_cnt", bus.drop_cnt, 8'hFF);

        // Randomized traffic against the model.
        do_reset("rnd");
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), rgap());
            send(HDR, 1'b0, rgap());
            s = 8'h00;
            for (int i = 0; i < P; i++) begin
                b  = 8'($urandom_range(0, 255));
                fe = ($urandom_range(0, 29) == 0);
                send(b, fe, rgap());
                s = s + b;
            end
            chk = s;
            if ($urandom_range(0, 3) == 0) chk = s + 8'($urandom_range(1, 255));
            send(chk, ($urandom_range(0, 29) == 0), rgap());
            if (holding) begin
                case ($urandom_range(0, 3))
                    0: begin
                        send(8'($urandom_range(0, 255)), 1'b0, 0);
                        cycle(1'b0, 8'h00, 1'b0, 1'b1);
                    end
                    1: cycle(1'b0, 8'h00, 1'b0, 1'b1);
                    2: ack_next = 1'b1;
                    default: begin
                        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
                        cycle(1'b0, 8'h00, 1'b0, 1'b1);
                    end
                endcase
            end
            if (it % 50 == 49) settle_check("rnd");
        end
        settle_check("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
